// File: rtl/multi_pad_pkg.sv
// Shared state encoding and default timing for the multi-pad serial controller reader.
package multi_pad_pkg;

  localparam int DEF_NUM_BITS    = 8;
  localparam int DEF_CLK_DIV     = 240;
  localparam int DEF_POLL_PERIOD = 666666;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LATCH    = 3'd1,
    PULSE_HI = 3'd2,
    PULSE_LO = 3'd3,
    PUBLISH  = 3'd4
  } state_t;

  // Counter width that can hold 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pad_shift_channel.sv
// One pad lane: 2-flop synchroniser into a NUM_BITS shift register, MSB-first, inverted to active-high.
// Latency: 2 cycles of synchroniser before a sample; no backpressure, shifts only on sample.
module pad_shift_channel
  import multi_pad_pkg::*;
#(
  parameter int NUM_BITS = DEF_NUM_BITS
) (
  input  logic                clk,
  input  logic                nrst,
  input  logic                pad_data,
  input  logic                sample,
  output logic [NUM_BITS-1:0] frame
);

  logic [1:0]          sync;
  logic [NUM_BITS-1:0] shreg;

  // Synchroniser resets to the released (high) line level.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sync  <= 2'b11;
      shreg <= '0;
    end else begin
      sync <= {sync[0], pad_data};
      if (sample) begin
        shreg <= {shreg[NUM_BITS-2:0], ~sync[1]};
      end
    end
  end

  assign frame = shreg;

endmodule

// File: rtl/multi_pad_reader.sv
// Reads NUM_PADS NES/SNES pads in lockstep over a shared latch/pulse pair; results publish 2*CLK_DIV*(NUM_BITS+1) cycles after latch rises.
// No backpressure: valid is a one-cycle strobe, outputs hold until the next completed frame.
module multi_pad_reader
  import multi_pad_pkg::*;
#(
  parameter int NUM_PADS    = 2,
  parameter int NUM_BITS    = DEF_NUM_BITS,
  parameter int CLK_DIV     = DEF_CLK_DIV,
  parameter int POLL_PERIOD = DEF_POLL_PERIOD
) (
  input  logic                         clk,
  input  logic                         nrst,
  input  logic                         en,
  input  logic                         poll_now,
  input  logic [NUM_PADS-1:0]          pad_data,
  output logic                         latch,
  output logic                         pulse,
  output logic [NUM_PADS*NUM_BITS-1:0] buttons,
  output logic [NUM_PADS*NUM_BITS-1:0] pressed,
  output logic [NUM_PADS*NUM_BITS-1:0] released,
  output logic                         valid,
  output logic                         busy
);

  localparam int W     = NUM_PADS * NUM_BITS;
  localparam int PH_W  = cnt_w(2 * CLK_DIV);
  localparam int BIT_W = cnt_w(NUM_BITS + 1);
  localparam int TMR_W = cnt_w(POLL_PERIOD);

  localparam logic [PH_W-1:0]  PH_LATCH_END = PH_W'(2 * CLK_DIV - 1);
  localparam logic [PH_W-1:0]  PH_HALF_END  = PH_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST     = BIT_W'(NUM_BITS - 1);
  localparam logic [TMR_W-1:0] TMR_END      = TMR_W'(POLL_PERIOD - 1);

  state_t             state, state_next;
  logic [PH_W-1:0]    phase, phase_next;
  logic [BIT_W-1:0]   bit_cnt, bit_next;
  logic [TMR_W-1:0]   timer;
  logic               sample, load, start;
  logic [W-1:0]       frame;

  for (genvar p = 0; p < NUM_PADS; p++) begin : g_pad
    pad_shift_channel #(
      .NUM_BITS (NUM_BITS)
    ) u_ch (
      .clk      (clk),
      .nrst     (nrst),
      .pad_data (pad_data[p]),
      .sample   (sample),
      .frame    (frame[p*NUM_BITS +: NUM_BITS])
    );
  end

  always_comb begin
    state_next = state;
    phase_next = phase + 1'b1;
    bit_next   = bit_cnt;
    sample     = 1'b0;
    load       = 1'b0;
    start      = 1'b0;
    case (state)
      IDLE: begin
        phase_next = '0;
        bit_next   = '0;
        if (en && (poll_now || timer == TMR_END)) begin
          state_next = LATCH;
          start      = 1'b1;
        end
      end
      LATCH: begin
        if (phase == PH_LATCH_END) begin
          sample     = 1'b1;
          phase_next = '0;
          state_next = PULSE_HI;
        end
      end
      PULSE_HI: begin
        if (phase == PH_HALF_END) begin
          phase_next = '0;
          state_next = PULSE_LO;
        end
      end
      PULSE_LO: begin
        if (phase == PH_HALF_END) begin
          phase_next = '0;
          // The last pulse only clocks the pad past its final bit; nothing left to sample.
          if (bit_cnt == BIT_LAST) begin
            load       = 1'b1;
            state_next = PUBLISH;
          end else begin
            sample     = 1'b1;
            bit_next   = bit_cnt + 1'b1;
            state_next = PULSE_HI;
          end
        end
      end
      PUBLISH: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    if (!en) begin
      state_next = IDLE;
      phase_next = '0;
      bit_next   = '0;
      sample     = 1'b0;
      load       = 1'b0;
    end
  end

  // Strobes are registered from the next state so the pad lines never see decode glitches.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state   <= IDLE;
      phase   <= '0;
      bit_cnt <= '0;
      latch   <= 1'b0;
      pulse   <= 1'b0;
    end else begin
      state   <= state_next;
      phase   <= phase_next;
      bit_cnt <= bit_next;
      latch   <= (state_next == LATCH);
      pulse   <= (state_next == PULSE_HI);
    end
  end

  // Timer saturates so an expiry during a frame starts the next one as soon as IDLE is reached.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      timer <= '0;
    end else if (start) begin
      timer <= '0;
    end else if (en && timer != TMR_END) begin
      timer <= timer + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      buttons  <= '0;
      pressed  <= '0;
      released <= '0;
    end else if (load) begin
      buttons  <= frame;
      pressed  <= frame & ~buttons;
      released <= ~frame & buttons;
    end
  end

  assign valid = (state == PUBLISH);
  assign busy  = (state != IDLE);

endmodule

// File: tb/tb_multi_pad_reader.sv
// Directed bench: pad models answer latch/pulse, a scoreboard queue holds the expected publish per frame.
module tb_multi_pad_reader;

  typedef struct packed {
    logic [31:0] b;
    logic [31:0] p;
    logic [31:0] r;
  } exp_t;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        en8 = 1'b0, poll8 = 1'b0, en16 = 1'b0, poll16 = 1'b0;
  logic [1:0]  pad8 = 2'b11, pad16 = 2'b11;
  logic        latch8, pulse8, valid8, busy8;
  logic        latch16, pulse16, valid16, busy16;
  logic [15:0] buttons8, pressed8, released8;
  logic [31:0] buttons16, pressed16, released16;

  logic [7:0]  pat8 [2];
  logic [15:0] pat16 [2];
  exp_t        sb8[$];
  exp_t        sb16[$];

  int checks = 0, errors = 0, cyc = 0;
  int nrise8 = 0, rise8 = 0, llen8 = 0, pcnt8 = 0, nvalid8 = 0;
  int nrise16 = 0, rise16 = 0, llen16 = 0, pcnt16 = 0, nvalid16 = 0;

  multi_pad_reader #(.NUM_PADS(2), .NUM_BITS(8), .CLK_DIV(4), .POLL_PERIOD(200)) dut8 (
    .clk(clk), .nrst(nrst), .en(en8), .poll_now(poll8), .pad_data(pad8),
    .latch(latch8), .pulse(pulse8), .buttons(buttons8), .pressed(pressed8),
    .released(released8), .valid(valid8), .busy(busy8)
  );

  multi_pad_reader #(.NUM_PADS(2), .NUM_BITS(16), .CLK_DIV(4), .POLL_PERIOD(200)) dut16 (
    .clk(clk), .nrst(nrst), .en(en16), .poll_now(poll16), .pad_data(pad16),
    .latch(latch16), .pulse(pulse16), .buttons(buttons16), .pressed(pressed16),
    .released(released16), .valid(valid16), .busy(busy16)
  );

  initial forever #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Pad model (shift register reloaded by latch, advanced on pulse rise) plus frame monitor.
  initial begin : mon8
    logic lq, pq;
    int   idx;
    exp_t e;
    lq = 1'b0; pq = 1'b0; idx = 0;
    forever begin
      @(negedge clk);
      if (latch8 && !lq) begin nrise8++; rise8 = cyc; llen8 = 0; pcnt8 = 0; idx = 0; end
      if (latch8) llen8++;
      if (pulse8 && !pq) begin pcnt8++; idx++; end
      lq = latch8; pq = pulse8;
      for (int p = 0; p < 2; p++) pad8[p] = (idx < 8) ? pat8[p][7-idx] : 1'b1;
      if (valid8) begin
        nvalid8++;
        chk("sb8_pending", 32'(sb8.size() > 0), 32'd1);
        if (sb8.size() > 0) begin
          e = sb8.pop_front();
          chk("buttons8", 32'(buttons8), e.b);
          chk("pressed8", 32'(pressed8), e.p);
          chk("released8", 32'(released8), e.r);
          chk("frame_len8", 32'(cyc - rise8), 32'd72);
          chk("latch_len8", 32'(llen8), 32'd8);
          chk("pulses8", 32'(pcnt8), 32'd8);
        end
      end
    end
  end

  initial begin : mon16
    logic lq, pq;
    int   idx;
    exp_t e;
    lq = 1'b0; pq = 1'b0; idx = 0;
    forever begin
      @(negedge clk);
      if (latch16 && !lq) begin nrise16++; rise16 = cyc; llen16 = 0; pcnt16 = 0; idx = 0; end
      if (latch16) llen16++;
      if (pulse16 && !pq) begin pcnt16++; idx++; end
      lq = latch16; pq = pulse16;
      for (int p = 0; p < 2; p++) pad16[p] = (idx < 16) ? pat16[p][15-idx] : 1'b1;
      if (valid16) begin
        nvalid16++;
        chk("sb16_pending", 32'(sb16.size() > 0), 32'd1);
        if (sb16.size() > 0) begin
          e = sb16.pop_front();
          chk("buttons16", buttons16, e.b);
          chk("pressed16", pressed16, e.p);
          chk("released16", released16, e.r);
          chk("frame_len16", 32'(cyc - rise16), 32'd136);
          chk("latch_len16", 32'(llen16), 32'd8);
          chk("pulses16", 32'(pcnt16), 32'd16);
        end
      end
    end
  end

  task automatic wait_rise8(input int n0, output int c);
    int n = 0;
    while (nrise8 == n0 && n < 400) begin @(negedge clk); n++; end
    chk("latch_rise_seen", 32'(nrise8 > n0), 32'd1);
    c = rise8;
  endtask

  task automatic wait_valid(input bit sel16, input int n0);
    int n = 0;
    while ((sel16 ? nvalid16 : nvalid8) == n0 && n < 400) begin @(negedge clk); n++; end
    chk(sel16 ? "valid16_seen" : "valid8_seen", 32'((sel16 ? nvalid16 : nvalid8) > n0), 32'd1);
  endtask

  initial begin : main
    int n0, nv, r1, r2, r3, r4, r5, k;
    pat8[0]  = 8'b11101111;
    pat8[1]  = 8'b11111111;
    pat16[0] = 16'hFFFE;
    pat16[1] = 16'hFFFF;

    repeat (3) @(negedge clk);
    chk("rst_latch", 32'(latch8), 32'd0);
    chk("rst_pulse", 32'(pulse8), 32'd0);
    chk("rst_valid", 32'(valid8), 32'd0);
    chk("rst_busy", 32'(busy8), 32'd0);
    chk("rst_buttons", 32'(buttons8), 32'd0);
    chk("rst_pressed", 32'(pressed8), 32'd0);
    chk("rst_released", 32'(released8), 32'd0);
    chk("rst_busy16", 32'(busy16), 32'd0);
    nrst = 1'b1;
    repeat (2) @(negedge clk);

    // Frame 1 by poll_now.
    sb8.push_back('{32'h0010, 32'h0010, 32'h0000});
    n0 = nrise8; nv = nvalid8;
    en8 = 1'b1; poll8 = 1'b1;
    @(negedge clk); poll8 = 1'b0;
    wait_rise8(n0, r1);
    wait_valid(1'b0, nv);

    // Frame 2 from the poll timer with a new press and a release.
    pat8[0] = 8'b11111101;
    sb8.push_back('{32'h0002, 32'h0002, 32'h0010});
    n0 = nrise8; nv = nvalid8;
    wait_rise8(n0, r2);
    chk("poll_period", 32'(r2 - r1), 32'd200);
    wait_valid(1'b0, nv);

    // Frame 3 identical; poll_now mid-frame must be dropped.
    sb8.push_back('{32'h0002, 32'h0000, 32'h0000});
    n0 = nrise8; nv = nvalid8;
    wait_rise8(n0, r3);
    chk("poll_period_2", 32'(r3 - r2), 32'd200);
    repeat (30) @(negedge clk);
    chk("busy_at_poll", 32'(busy8), 32'd1);
    poll8 = 1'b1;
    @(negedge clk); poll8 = 1'b0;
    wait_valid(1'b0, nv);

    // Frame 4 is aborted by en during the fourth pulse-high.
    n0 = nrise8;
    wait_rise8(n0, r4);
    chk("poll_ignored_busy", 32'(r4 - r3), 32'd200);
    k = 0;
    while (pcnt8 < 4 && k < 100) begin @(negedge clk); k++; end
    chk("abort_pulse_idx", 32'(pcnt8), 32'd4);
    chk("abort_in_pulse_hi", 32'(pulse8), 32'd1);
    en8 = 1'b0;
    @(negedge clk);
    chk("abort_latch", 32'(latch8), 32'd0);
    chk("abort_pulse", 32'(pulse8), 32'd0);
    chk("abort_busy", 32'(busy8), 32'd0);
    repeat (100) @(negedge clk);
    chk("abort_buttons", 32'(buttons8), 32'h0002);
    chk("abort_pressed", 32'(pressed8), 32'h0000);
    chk("abort_released", 32'(released8), 32'h0000);

    // Asynchronous reset in the middle of a frame.
    n0 = nrise8;
    en8 = 1'b1; poll8 = 1'b1;
    @(negedge clk); poll8 = 1'b0;
    wait_rise8(n0, r5);
    repeat (20) @(negedge clk);
    chk("pre_rst_busy", 32'(busy8), 32'd1);
    #2 nrst = 1'b0;
    #1;
    chk("arst_busy", 32'(busy8), 32'd0);
    chk("arst_latch_pulse", 32'({latch8, pulse8}), 32'd0);
    chk("arst_valid", 32'(valid8), 32'd0);
    chk("arst_buttons", 32'(buttons8), 32'd0);
    en8 = 1'b0;
    @(negedge clk); nrst = 1'b1;
    repeat (3) @(negedge clk);

    // After reset the previous state is zero, so nothing is reported released.
    pat8[0] = 8'b11101111;
    pat8[1] = 8'b11111110;
    sb8.push_back('{32'h0110, 32'h0110, 32'h0000});
    nv = nvalid8;
    en8 = 1'b1; poll8 = 1'b1;
    @(negedge clk); poll8 = 1'b0;
    wait_valid(1'b0, nv);
    en8 = 1'b0;

    // SNES-width frame; pad 1 left floating high reads as all released.
    sb16.push_back('{32'h0000_0001, 32'h0000_0001, 32'h0000_0000});
    nv = nvalid16;
    en16 = 1'b1; poll16 = 1'b1;
    @(negedge clk); poll16 = 1'b0;
    wait_valid(1'b1, nv);
    en16 = 1'b0;

    repeat (5) @(negedge clk);
    chk("sb8_drained", 32'(sb8.size()), 32'd0);
    chk("sb16_drained", 32'(sb16.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
